// File: rtl/smmha_tile_scheduler.sv
// Tile scheduler for the SMMHA accelerator: splits one job into bounded tiles and
// sequences start/done handshakes with per-tile base addresses and lengths.
module smmha_tile_scheduler #(
  parameter int unsigned AW  = 32,
  parameter int unsigned LW  = 16,
  parameter int unsigned BPE = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          job_valid_i,
  output logic          job_ready_o,
  input  logic [AW-1:0] job_in_addr_i,
  input  logic [AW-1:0] job_out_addr_i,
  input  logic [LW-1:0] job_len_i,
  input  logic [LW-1:0] job_tile_len_i,
  output logic          tile_start_o,
  output logic [AW-1:0] tile_in_addr_o,
  output logic [AW-1:0] tile_out_addr_o,
  output logic [LW-1:0] tile_len_o,
  input  logic          tile_done_i,
  output logic          busy_o,
  output logic          job_done_o,
  output logic [LW-1:0] tiles_issued_o
);

  localparam int unsigned BpeShift = $clog2(BPE);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StFin} state_e;

  state_e state_q, state_d;

  logic [AW-1:0] in_addr_q, in_addr_d;
  logic [AW-1:0] out_addr_q, out_addr_d;
  logic [LW-1:0] tile_cfg_q, tile_cfg_d;
  logic [LW-1:0] remaining_q, remaining_d;
  logic [LW-1:0] tile_len_q, tile_len_d;
  logic [LW-1:0] issued_q, issued_d;

  logic [LW-1:0] rem_next;
  logic [AW-1:0] addr_step;

  // Tile length for a given remaining count; a zero tile config means one tile.
  function automatic logic [LW-1:0] clip_len(input logic [LW-1:0] rem,
                                             input logic [LW-1:0] cfg);
    return ((cfg == '0) || (cfg > rem)) ? rem : cfg;
  endfunction

  assign rem_next  = remaining_q - tile_len_q;
  assign addr_step = AW'(tile_len_q) << BpeShift;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (job_valid_i) state_d = (job_len_i == '0) ? StFin : StIssue;
        end
        StIssue: state_d = StWait;
        StWait: begin
          if (tile_done_i) state_d = (rem_next == '0) ? StFin : StIssue;
        end
        StFin:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    job_ready_o  = (state_q == StIdle);
    busy_o       = (state_q != StIdle);
    tile_start_o = (state_q == StIssue);
    job_done_o   = (state_q == StFin);
  end

  // Datapath next-state: the next tile's parameters are prepared before ISSUE
  always_comb begin
    in_addr_d   = in_addr_q;
    out_addr_d  = out_addr_q;
    tile_cfg_d  = tile_cfg_q;
    remaining_d = remaining_q;
    tile_len_d  = tile_len_q;
    issued_d    = issued_q;
    if (clear_i) begin
      in_addr_d   = '0;
      out_addr_d  = '0;
      tile_cfg_d  = '0;
      remaining_d = '0;
      tile_len_d  = '0;
      issued_d    = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (job_valid_i) begin
            in_addr_d   = job_in_addr_i;
            out_addr_d  = job_out_addr_i;
            tile_cfg_d  = job_tile_len_i;
            remaining_d = job_len_i;
            tile_len_d  = clip_len(job_len_i, job_tile_len_i);
            issued_d    = '0;
          end
        end
        StIssue: issued_d = issued_q + 1'b1;
        StWait: begin
          if (tile_done_i) begin
            remaining_d = rem_next;
            in_addr_d   = in_addr_q + addr_step;
            out_addr_d  = out_addr_q + addr_step;
            tile_len_d  = clip_len(rem_next, tile_cfg_q);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_addr_q   <= '0;
      out_addr_q  <= '0;
      tile_cfg_q  <= '0;
      remaining_q <= '0;
      tile_len_q  <= '0;
      issued_q    <= '0;
    end else begin
      in_addr_q   <= in_addr_d;
      out_addr_q  <= out_addr_d;
      tile_cfg_q  <= tile_cfg_d;
      remaining_q <= remaining_d;
      tile_len_q  <= tile_len_d;
      issued_q    <= issued_d;
    end
  end

  assign tile_in_addr_o  = in_addr_q;
  assign tile_out_addr_o = out_addr_q;
  assign tile_len_o      = tile_len_q;
  assign tiles_issued_o  = issued_q;

endmodule
